mem_bus_arb: RTL and testbench
==============================

// Module: mem_bus_arb
// PURPOSE
// - Shares the single memory bus between the core data port (M0) and the io_hub DMA master (M1).
// - Sits between core/io_top and memory. Per-cycle handshake is cyc/stb/we/addr/data with ack.
// - DMA has priority, but a burst limit hands the bus to a waiting core between DMA transfers.
// PARAMETERS
// - AW            16   address width
// - DW            32   data width
// - DMA_BURST_MAX 8    acked DMA transfers before a waiting core is granted (1..255)
// - TIMEOUT       255  cycles without ack before abort; used only with MEM_TIMEOUT_EN (1..255)
// PORTS
// - sys_clk     in   1   system clock. One clock domain.
// - sys_rst_n   in   1   reset, asynchronous and active-low
// - core_cyc_i  in   1   core bus cycle request
// - core_stb_i  in   1   core strobe
// - core_we_i   in   1   core write enable
// - core_addr_i in   AW  core address
// - core_data_i in   DW  core write data
// - core_data_o out  DW  read data to core
// - core_ack_o  out  1   ack to core
// - dma_cyc_i   in   1   DMA bus cycle request
// - dma_stb_i   in   1   DMA strobe
// - dma_we_i    in   1   DMA write enable
// - dma_addr_i  in   AW  DMA address
// - dma_data_i  in   DW  DMA write data
// - dma_data_o  out  DW  read data to DMA
// - dma_ack_o   out  1   ack to DMA
// - mem_cyc_o   out  1   memory cycle
// - mem_stb_o   out  1   memory strobe
// - mem_we_o    out  1   memory write enable
// - mem_addr_o  out  AW  memory address
// - mem_data_o  out  DW  memory write data
// - mem_data_i  in   DW  memory read data
// - mem_ack_i   in   1   memory ack
// - gnt_o       out  2   registered grant: 01 = core, 10 = DMA, 00 = none
// - arb_err_o   out  1   one-cycle timeout error pulse. Tied 0 without MEM_TIMEOUT_EN.
// BEHAVIOUR
// - Reset state: IDLE, gnt_o = 00, burst counter = 0, all mem_* outputs, acks and arb_err_o = 0.
// - FSM states: IDLE, GNT_CORE, GNT_DMA. The grant is registered.
// - IDLE: if dma_cyc_i, go to GNT_DMA; else if core_cyc_i, go to GNT_CORE. DMA wins a tie.
// - Grant latency: request seen at edge N, mem_cyc_o asserted in cycle N+1.
// - While granted, mem_cyc/stb/we/addr/data are a combinational copy of the owner's signals.
// - In IDLE, mem_* outputs are driven to 0.
// - mem_ack_i is routed only to the owner's ack, same cycle. The non-owner ack is 0.
// - mem_data_i is fanned out to both *_data_o. Only the owner's ack qualifies it.
// - GNT_CORE is not preemptible. It releases when core_cyc_i = 0 at an edge.
// - On release from GNT_CORE: if dma_cyc_i, go to GNT_DMA (direct handoff); else go to IDLE.
// - Entering GNT_DMA clears the burst counter. Each DMA mem_ack_i increments it, saturating at 255.
// - GNT_DMA releases on dma_cyc_i = 0, or on (counter >= DMA_BURST_MAX and core_cyc_i and no stb pending ack).
// - On release from GNT_DMA: if core_cyc_i, go to GNT_CORE; else go to IDLE.
// - Preempted DMA keeps cyc/stb asserted and stalls: no ack, not forwarded.
// - A preempted DMA is regranted when the core releases.
// - Never preempt while mem_stb_o = 1 and ack is outstanding. Preemption only between acked transfers.
// - Reset mid-transfer: outputs drop to 0 immediately (async). The FSM returns to IDLE.
// - mem_ack_i while in IDLE is ignored.
// CONFIGURATION
// - With MEM_TIMEOUT_EN defined: a cycle counter runs while mem_stb_o = 1 and mem_ack_i = 0.
//   - When the counter reaches TIMEOUT: pulse arb_err_o and ack the owner once (data invalid).
//   - Then force release: GNT_CORE or GNT_DMA goes to IDLE, or hands off per the rules above.
//   - The counter clears on each ack and on each grant change.
// - Without MEM_TIMEOUT_EN: no timeout counter, arb_err_o = 0, and a missing ack stalls forever.
// TESTING
// - Core-only read of 0x0040, mem returns 0xDEADBEEF after 2 cycles.
//   -> gnt_o = 01, core_ack_o for 1 cycle with data; dma_ack_o = 0.
// - core_cyc_i and dma_cyc_i rise on the same edge -> gnt_o = 10 first.
//   -> Core is granted the cycle after DMA drops cyc.
// - DMA 20-word write burst, core requests at DMA word 3, DMA_BURST_MAX = 8.
//   -> Core is granted after DMA ack 8. DMA resumes after the core releases.
//   -> Mem sees all 20 DMA writes.
// - Core holds the bus for 10 transfers while DMA requests -> no preemption.
//   -> Direct handoff to DMA, with no IDLE cycle.
// - sys_rst_n low during a DMA write with stb high -> mem_cyc_o = 0 immediately.
//   -> gnt_o = 00. After reset, a DMA request is regranted at latency 1.
// - MEM_TIMEOUT_EN, TIMEOUT = 16, mem never acks a core read.
//   -> At the 16th stall cycle, arb_err_o = 1 for 1 cycle and core_ack_o = 1. Then FSM = IDLE.

Source files
------------

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: shares one memory bus between the core data port and the DMA master.
//
// DMA has priority. After DMA_BURST_MAX acked DMA transfers, a waiting core
// is handed the bus between two DMA transfers. The DMA keeps its request
// asserted and resumes once the core releases.
//
// Optional feature (macro MEM_TIMEOUT_EN): abort a transfer after TIMEOUT
// cycles without ack. The owner gets one ack with invalid data, arb_err_o
// pulses, and the grant is released.
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   core_*_i / core_*_o       core master (cyc, stb, we, addr, wdata / rdata, ack)
//   dma_*_i  / dma_*_o        DMA master (same handshake)
//   mem_*_o  / mem_*_i        memory slave side
//   gnt_o                     registered grant: 01 core, 10 DMA, 00 none
//   arb_err_o                 one-cycle timeout pulse (0 without MEM_TIMEOUT_EN)
module mem_bus_arb #(
  parameter int AW            = 16,
  parameter int DW            = 32,
  parameter int DMA_BURST_MAX = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          core_cyc_i,
  input  logic          core_stb_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_data_i,
  output logic [DW-1:0] core_data_o,
  output logic          core_ack_o,
  input  logic          dma_cyc_i,
  input  logic          dma_stb_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_data_i,
  output logic [DW-1:0] dma_data_o,
  output logic          dma_ack_o,
  output logic          mem_cyc_o,
  output logic          mem_stb_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i,
  input  logic          mem_ack_i,
  output logic [1:0]    gnt_o,
  output logic          arb_err_o
);

  // State encoding doubles as the grant vector, so gnt_o is the state flop.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CORE = 2'b01;
  localparam logic [1:0] S_DMA  = 2'b10;
  localparam logic [7:0] BURST_MAX = 8'(DMA_BURST_MAX);

  logic [1:0] state_q, state_d;
  logic [7:0] burst_q, burst_d;
  logic [7:0] burst_inc_s;
  logic       own_core_s, own_dma_s;
  logic       stb_fwd_s, pending_s, burst_lim_s, timeout_s;

  assign own_core_s = (state_q == S_CORE);
  assign own_dma_s  = (state_q == S_DMA);
  assign stb_fwd_s  = own_core_s ? core_stb_i : (own_dma_s ? dma_stb_i : 1'b0);
  // A strobe without ack this cycle is a transfer still in flight.
  assign pending_s  = stb_fwd_s & ~mem_ack_i;

  // Burst count including this cycle's ack, so the core can take over on the
  // very edge that completes the limiting DMA transfer.
  assign burst_inc_s = (own_dma_s && mem_ack_i && (burst_q != 8'hFF)) ?
                       (burst_q + 8'd1) : burst_q;
  assign burst_lim_s = (burst_inc_s >= BURST_MAX) & core_cyc_i & ~pending_s;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;

  // Fires during the TIMEOUT-th consecutive stall cycle.
  assign timeout_s = pending_s & (tmo_q == TMO_LAST);

  // Stall counter next value: cleared on grant change and on any ack.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) begin
      tmo_d = 8'd0;
    end else if (mem_ack_i || timeout_s) begin
      tmo_d = 8'd0;
    end else if (pending_s) begin
      tmo_d = tmo_q + 8'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^8'(TIMEOUT);
  assign timeout_s    = 1'b0;
`endif

  assign arb_err_o = timeout_s;
  assign gnt_o     = state_q;

  // State and burst counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      burst_q <= 8'd0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Next-state and burst counter logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dma_cyc_i) begin
          state_d = S_DMA;
        end else if (core_cyc_i) begin
          state_d = S_CORE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CORE: begin
        // Core is never preempted; on release a waiting DMA takes over directly.
        if (!core_cyc_i || timeout_s) begin
          state_d = dma_cyc_i ? S_DMA : S_IDLE;
        end else begin
          state_d = S_CORE;
        end
      end
      S_DMA: begin
        if (!dma_cyc_i || timeout_s || burst_lim_s) begin
          state_d = core_cyc_i ? S_CORE : S_IDLE;
        end else begin
          state_d = S_DMA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d == S_DMA) && (state_q != S_DMA)) begin
      burst_d = 8'd0;
    end else begin
      burst_d = burst_inc_s;
    end
  end

  // Bus mux: owner's signals go to memory, memory ack goes to the owner only.
  always_comb begin
    mem_cyc_o   = 1'b0;
    mem_stb_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {AW{1'b0}};
    mem_data_o  = {DW{1'b0}};
    core_ack_o  = 1'b0;
    dma_ack_o   = 1'b0;
    core_data_o = mem_data_i;
    dma_data_o  = mem_data_i;
    case (state_q)
      S_CORE: begin
        mem_cyc_o  = core_cyc_i;
        mem_stb_o  = core_stb_i;
        mem_we_o   = core_we_i;
        mem_addr_o = core_addr_i;
        mem_data_o = core_data_i;
        core_ack_o = mem_ack_i | timeout_s;
      end
      S_DMA: begin
        mem_cyc_o  = dma_cyc_i;
        mem_stb_o  = dma_stb_i;
        mem_we_o   = dma_we_i;
        mem_addr_o = dma_addr_i;
        mem_data_o = dma_data_i;
        dma_ack_o  = mem_ack_i | timeout_s;
      end
      default: begin
        mem_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
module tb_mem_bus_arb;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic core_cyc, core_stb, core_we, core_ack;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic dma_cyc, dma_stb, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic mem_cyc, mem_stb, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0] gnt;
  logic arb_err;

  int checks = 0;
  int fails = 0;

  mem_bus_arb #(.AW(AW), .DW(DW), .DMA_BURST_MAX(8), .TIMEOUT(16)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .core_cyc_i(core_cyc), .core_stb_i(core_stb), .core_we_i(core_we),
    .core_addr_i(core_addr), .core_data_i(core_wdata), .core_data_o(core_rdata),
    .core_ack_o(core_ack),
    .dma_cyc_i(dma_cyc), .dma_stb_i(dma_stb), .dma_we_i(dma_we),
    .dma_addr_i(dma_addr), .dma_data_i(dma_wdata), .dma_data_o(dma_rdata),
    .dma_ack_o(dma_ack),
    .mem_cyc_o(mem_cyc), .mem_stb_o(mem_stb), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata),
    .mem_ack_i(mem_ack),
    .gnt_o(gnt), .arb_err_o(arb_err)
  );

  // Memory model: ack arrives lat+1 cycles after the strobe is first seen.
  int lat = 1;
  bit silent = 1'b0;
  int wcnt = 0;
  int wr_cnt = 0;
  logic [31:0] wlog [0:255];

  function automatic logic [31:0] rd_val(input logic [15:0] a);
    return (a == 16'h0040) ? 32'hDEADBEEF : {16'hA5A5, a};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack <= 1'b0;
      mem_rdata <= 32'h0;
      wcnt <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      wcnt <= 0;
    end else if (mem_stb && !silent) begin
      if (wcnt >= lat) begin
        mem_ack <= 1'b1;
        wcnt <= 0;
        if (mem_we) begin
          wlog[mem_addr[7:0]] <= mem_wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          mem_rdata <= rd_val(mem_addr);
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic test_reset;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if ({mem_cyc, mem_stb, mem_we} !== 3'b000) begin fails++; $display("FAIL reset_mem_ctl: got %b expected 000", {mem_cyc, mem_stb, mem_we}); end
    checks++; if ({mem_addr, mem_wdata} !== 48'h0) begin fails++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata}); end
    checks++; if ({core_ack, dma_ack, arb_err} !== 3'b000) begin fails++; $display("FAIL reset_acks: got %b expected 000", {core_ack, dma_ack, arb_err}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL idle_gnt: got %b expected 00", gnt); end
  endtask

  task automatic test_core_read;
    int n;
    core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b0; core_addr = 16'h0040;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL core_gnt: got %b expected 01", gnt); end
    checks++; if (mem_cyc !== 1'b1 || mem_addr !== 16'h0040) begin fails++; $display("FAIL core_fwd: got cyc=%b addr=%h expected 1/0040", mem_cyc, mem_addr); end
    n = 0;
    while (!core_ack && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 2) begin fails++; $display("FAIL core_ack_latency: got %0d expected 2", n); end
    checks++; if (core_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL core_rdata: got %h expected deadbeef", core_rdata); end
    checks++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL core_dma_ack: got %b expected 0", dma_ack); end
    core_cyc = 1'b0; core_stb = 1'b0;
    @(negedge clk);
    checks++; if (core_ack !== 1'b0 || gnt !== 2'b00) begin fails++; $display("FAIL core_release: got ack=%b gnt=%b expected 0/00", core_ack, gnt); end
  endtask

  task automatic test_tie;
    int n;
    core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b0; core_addr = 16'h0048;
    dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b1; dma_addr = 16'h00A0; dma_wdata = 32'h1111_2222;
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin fails++; $display("FAIL tie_gnt: got %b expected 10", gnt); end
    n = 0;
    while (!dma_ack && n < 20) begin @(negedge clk); n++; end
    dma_cyc = 1'b0; dma_stb = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL tie_handoff: got %b expected 01", gnt); end
    n = 0;
    while (!core_ack && n < 20) begin @(negedge clk); n++; end
    checks++; if (core_rdata !== 32'hA5A5_0048) begin fails++; $display("FAIL tie_rdata: got %h expected a5a50048", core_rdata); end
    core_cyc = 1'b0; core_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst;
    int dma_acks = 0;
    int acks_at_grant = -1;
    int w0;
    int bad_ack = 0;
    w0 = wr_cnt;
    fork
      begin : dma_master
        int i = 0;
        int guard = 0;
        dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b1;
        dma_addr = 16'h0080; dma_wdata = 32'hD000_0000;
        while (i < 20 && guard < 2000) begin
          @(negedge clk); guard++;
          if (dma_ack) begin
            i++; dma_acks = i;
            if (i < 20) begin
              dma_addr = 16'h0080 + 16'(i); dma_wdata = 32'hD000_0000 + 32'(i);
            end else begin
              dma_cyc = 1'b0; dma_stb = 1'b0;
            end
          end
        end
        dma_cyc = 1'b0; dma_stb = 1'b0;
      end
      begin : core_master
        int g = 0;
        while (dma_acks < 3 && g < 500) begin @(negedge clk); g++; end
        core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b0; core_addr = 16'h0044;
        g = 0;
        while (gnt !== 2'b01 && g < 500) begin @(negedge clk); g++; end
        acks_at_grant = dma_acks;
        g = 0;
        while (!core_ack && g < 50) begin
          if (dma_ack) bad_ack++;
          @(negedge clk); g++;
        end
        core_cyc = 1'b0; core_stb = 1'b0;
      end
    join
    @(negedge clk);
    checks++; if (acks_at_grant !== 8) begin fails++; $display("FAIL burst_preempt_point: got %0d expected 8", acks_at_grant); end
    checks++; if (bad_ack !== 0) begin fails++; $display("FAIL burst_stalled_dma_ack: got %0d expected 0", bad_ack); end
    checks++; if (dma_acks !== 20) begin fails++; $display("FAIL burst_dma_acks: got %0d expected 20", dma_acks); end
    checks++; if (wr_cnt - w0 !== 20) begin fails++; $display("FAIL burst_mem_writes: got %0d expected 20", wr_cnt - w0); end
    for (int k = 0; k < 20; k++) begin
      logic [31:0] exp_w;
      exp_w = 32'hD000_0000 + 32'(k);
      checks++; if (wlog[8'h80 + 8'(k)] !== exp_w) begin fails++; $display("FAIL burst_word%0d: got %h expected %h", k, wlog[8'h80 + 8'(k)], exp_w); end
    end
  endtask

  task automatic test_core_hold;
    int n;
    int taken = 0;
    core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b0; core_addr = 16'h0050;
    for (int t = 0; t < 10; t++) begin
      n = 0;
      @(negedge clk);
      while (!core_ack && n < 20) begin
        if (gnt !== 2'b01) taken++;
        @(negedge clk); n++;
      end
      if (t == 0) begin
        dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b1; dma_addr = 16'h00C0; dma_wdata = 32'hCAFE_0001;
      end
    end
    core_cyc = 1'b0; core_stb = 1'b0;
    checks++; if (taken !== 0) begin fails++; $display("FAIL hold_no_preempt: got %0d expected 0", taken); end
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin fails++; $display("FAIL hold_handoff_gnt: got %b expected 10", gnt); end
    checks++; if (mem_cyc !== 1'b1 || mem_addr !== 16'h00C0) begin fails++; $display("FAIL hold_handoff_bus: got cyc=%b addr=%h expected 1/00c0", mem_cyc, mem_addr); end
    n = 0;
    while (!dma_ack && n < 20) begin @(negedge clk); n++; end
    dma_cyc = 1'b0; dma_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    lat = 6;
    dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b1; dma_addr = 16'h00D0; dma_wdata = 32'h5555_AAAA;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_stb !== 1'b1 || mem_ack !== 1'b0) begin fails++; $display("FAIL rstmid_pending: got stb=%b ack=%b expected 1/0", mem_stb, mem_ack); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_cyc !== 1'b0 || mem_stb !== 1'b0) begin fails++; $display("FAIL rstmid_async: got cyc=%b stb=%b expected 0/0", mem_cyc, mem_stb); end
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL rstmid_gnt: got %b expected 00", gnt); end
    @(negedge clk);
    rst_n = 1'b1; lat = 1;
    @(negedge clk);
    checks++; if (gnt !== 2'b10 || mem_cyc !== 1'b1) begin fails++; $display("FAIL rstmid_regrant: got gnt=%b cyc=%b expected 10/1", gnt, mem_cyc); end
    n = 0;
    while (!dma_ack && n < 20) begin @(negedge clk); n++; end
    dma_cyc = 1'b0; dma_stb = 1'b0;
    @(negedge clk);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int k = 0;
    int err_at = -1;
    logic ack_at_err = 1'b0;
    silent = 1'b1;
    core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b0; core_addr = 16'h0060;
    while (err_at < 0 && k < 40) begin
      @(negedge clk); k++;
      if (arb_err) begin err_at = k; ack_at_err = core_ack; end
    end
    core_cyc = 1'b0; core_stb = 1'b0;
    checks++; if (err_at !== 16) begin fails++; $display("FAIL timeout_cycle: got %0d expected 16", err_at); end
    checks++; if (ack_at_err !== 1'b1) begin fails++; $display("FAIL timeout_ack: got %b expected 1", ack_at_err); end
    @(negedge clk);
    checks++; if (gnt !== 2'b00 || arb_err !== 1'b0) begin fails++; $display("FAIL timeout_release: got gnt=%b err=%b expected 00/0", gnt, arb_err); end
    silent = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    core_cyc = 1'b0; core_stb = 1'b0; core_we = 1'b0; core_addr = 16'h0; core_wdata = 32'h0;
    dma_cyc = 1'b0; dma_stb = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 32'h0;
    test_reset();
    test_core_read();
    test_tie();
    test_burst();
    test_core_hold();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
